// File: rtl/control.sv
// Shared control-word encodings for the memory interface.
// Op codes, bus width and the bus-consumer classification live here.
package control;

  localparam int DATA_WIDTH   = 8;
  localparam int MEM_OP_WIDTH = 3;

  typedef enum logic [MEM_OP_WIDTH-1:0] {
    MEM_NOP       = 3'd0,
    MEM_FETCH     = 3'd1,
    MEM_READ      = 3'd2,
    MEM_WRITE     = 3'd3,
    MEM_LOAD_MAR  = 3'd4,
    MEM_LOAD_PC   = 3'd5,
    MEM_PC_TO_MAR = 3'd6,
    MEM_JUMP      = 3'd7
  } memory_op_e;

  // Ops that sample bus_in this cycle; the unit must not drive the bus then.
  function automatic logic consumes_bus(input memory_op_e op);
    return (op == MEM_WRITE)    ||
           (op == MEM_LOAD_MAR) ||
           (op == MEM_LOAD_PC);
  endfunction

endpackage

// File: rtl/memory_array.sv
// Byte-wide RAM: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module memory_array
  import control::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/memory_unit.sv
// Responder for memory control words: owns PC, MAR, data register and RAM,
// drives the shared bus on request and flags drive/consume conflicts.
module memory_unit
  import control::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  memory_op_e            memory_op,
  input  logic                  data_word_selector,
  input  logic                  bus_selector,
  input  logic [DATA_WIDTH-1:0] bus_in,
  output logic [DATA_WIDTH-1:0] bus_out,
  output logic                  bus_out_en,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] mar,
  output logic                  bus_conflict,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data
);

  if (ADDR_WIDTH < 9 || ADDR_WIDTH > 16) begin : g_bad_width
    $error("memory_unit: ADDR_WIDTH must be 9..16");
  end

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_mar;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_conflict;

  logic                  w_consume;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [ADDR_WIDTH-1:0] w_raddr;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Hi select fills bits above 7 from the low bits of the bus byte.
  function automatic logic [ADDR_WIDTH-1:0] f_byte_load(
    input logic [ADDR_WIDTH-1:0] cur,
    input logic [DATA_WIDTH-1:0] b,
    input logic                  hi
  );
    logic [ADDR_WIDTH-1:0] v;
    v = cur;
    if (hi) begin
      v[ADDR_WIDTH-1:8] = b[ADDR_WIDTH-9:0];
    end else begin
      v[7:0] = b;
    end
    return v;
  endfunction

  assign w_consume  = consumes_bus(memory_op);
  assign bus_out_en = bus_selector & ~w_consume;

  // Preload owns the write port; a same-cycle core WRITE is dropped.
  assign w_we    = ~reset & (prog_we | (memory_op == MEM_WRITE));
  assign w_waddr = prog_we ? prog_addr : r_mar;
  assign w_wdata = prog_we ? prog_data : bus_in;
  assign w_raddr = (memory_op == MEM_FETCH) ? r_pc : r_mar;

  memory_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clock),
    .we   (w_we),
    .waddr(w_waddr),
    .wdata(w_wdata),
    .raddr(w_raddr),
    .rdata(w_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc       <= '0;
      r_mar      <= '0;
      r_data     <= '0;
      r_conflict <= 1'b0;
    end else begin
      if (bus_selector && w_consume) begin
        r_conflict <= 1'b1;
      end
      unique case (memory_op)
        MEM_NOP, MEM_WRITE: ;
        MEM_FETCH: begin
          r_data <= w_rdata;
          r_pc   <= r_pc + 1'b1;
        end
        MEM_READ:      r_data <= w_rdata;
        MEM_LOAD_MAR:  r_mar  <= f_byte_load(r_mar, bus_in,
                                             data_word_selector);
        MEM_LOAD_PC:   r_pc   <= f_byte_load(r_pc, bus_in,
                                             data_word_selector);
        MEM_PC_TO_MAR: r_mar  <= r_pc;
        MEM_JUMP:      r_pc   <= r_mar;
      endcase
    end
  end

  assign bus_out      = r_data;
  assign pc           = r_pc;
  assign mar          = r_mar;
  assign bus_conflict = r_conflict;

endmodule
